joint_pwmdir: RTL and testbench

JOINT_PWMDIR -- requirements
Module: joint_pwmdir

---
 rtl/joint_pwmdir.sv | 66 ++++++
 tb/tb_joint_pwmdir.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/joint_pwmdir.sv
// rtl/joint_pwmdir.sv - PWM/direction joint driver with position feedback counter
// Optional feedback accumulator enabled by JOINT_PWMDIR_FEEDBACK_EN.
module joint_pwmdir #(
    parameter int PWM_PERIOD = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [31:0] jointFreqCmd,
    output logic signed [31:0] jointFeedback,
    output logic               PWM,
    output logic               DIR
);
    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam logic [CW-1:0] LAST  = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] FULL  = CW'(PWM_PERIOD);
    localparam logic [31:0]   PER32 = 32'(PWM_PERIOD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] duty_l;
    logic [CW-1:0] duty_nxt;
    logic [31:0]   cmd_u;
    logic [31:0]   mag;
    logic          wrap;

    // Unsigned negation keeps -2^31 as 2^31, which then clamps to the period.
    always_comb begin
        cmd_u    = jointFreqCmd;
        mag      = cmd_u[31] ? (~cmd_u + 32'd1) : cmd_u;
        duty_nxt = (mag >= PER32) ? FULL : mag[CW-1:0];
        wrap     = (cnt == LAST);
        cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    end

    // PWM is computed from the next count and duty so it lines up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_l <= '0;
            PWM    <= 1'b0;
            DIR    <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (wrap) begin
                duty_l <= duty_nxt;
                DIR    <= cmd_u[31];
                PWM    <= (duty_nxt != '0);
            end else begin
                PWM    <= (cnt_nxt < duty_l);
            end
        end
    end

`ifdef JOINT_PWMDIR_FEEDBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jointFeedback <= '0;
        end else if (PWM) begin
            jointFeedback <= DIR ? jointFeedback - 32'sd1 : jointFeedback + 32'sd1;
        end
    end
`else
    assign jointFeedback = '0;
`endif

endmodule

// File: tb/tb_joint_pwmdir.sv
// tb/tb_joint_pwmdir.sv - self-checking bench for joint_pwmdir
module tb_joint_pwmdir;
    localparam int P = 256;
`ifdef JOINT_PWMDIR_FEEDBACK_EN
    localparam bit FB_ON = 1'b1;
`else
    localparam bit FB_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [31:0] cmd = 32'sd128;
    logic signed [31:0] fb;
    logic               pwm;
    logic               dir;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    joint_pwmdir #(.PWM_PERIOD(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jointFreqCmd (cmd),
        .jointFeedback(fb),
        .PWM          (pwm),
        .DIR          (dir)
    );

    always #5 clk = ~clk;

    // Model: time since release decides the period slot; the command seen
    // at each period start fixes that period's high count and direction.
    int unsigned m_t;
    longint      m_duty;
    logic        m_dir;
    logic        m_pwm;
    logic [31:0] m_fb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_duty = 0; m_dir = 1'b0; m_pwm = 1'b0; m_fb = 32'd0;
        end else begin
            longint c;
            if (FB_ON && m_pwm) m_fb = m_dir ? m_fb - 32'd1 : m_fb + 32'd1;
            m_t++;
            if (m_t % P == 0) begin
                c      = longint'(cmd);
                if (c < 0) c = -c;
                m_duty = (c > P) ? P : c;
                m_dir  = (cmd < 0);
            end
            m_pwm = longint'(m_t % P) < m_duty;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0d", name, act, exp, m_t);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pwm", {31'd0, pwm}, {31'd0, m_pwm});
            chk("dir", {31'd0, dir}, {31'd0, m_dir});
            chk("feedback", fb, m_fb);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input string name, input logic p, input logic d, input logic [31:0] f);
        chk({name, "_pwm"}, {31'd0, pwm}, {31'd0, p});
        chk({name, "_dir"}, {31'd0, dir}, {31'd0, d});
        chk({name, "_fb"}, fb, f);
        chk({name, "_model_fb"}, m_fb, f);
    endtask

    task automatic reset_midpulse(input string name);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 pin(name, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        run(3);
        pin("reset", 1'b0, 1'b0, 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Command 128: first period low, then 128 high per period.
        run(P);
        pin("p1_end", 1'b1, 1'b0, 32'd0);
        run(2 * P);
        pin("cmd128", 1'b1, 1'b0, FB_ON ? 32'd256 : 32'd0);

        // Mid-period change to 128000 does not disturb the running pulse.
        run(64);
        cmd = 32'sd128000;
        run(P - 64);
        pin("chg_start", 1'b1, 1'b0, FB_ON ? 32'd384 : 32'd0);
        run(P);
        pin("full_duty", 1'b1, 1'b0, FB_ON ? 32'd640 : 32'd0);

        reset_midpulse("rst_a");
        run(3);
        @(negedge clk);
        cmd   = -32'sd64;
        rst_n = 1'b1;
        run(P);
        pin("neg_start", 1'b1, 1'b1, 32'd0);
        run(P);
        pin("neg64", 1'b1, 1'b1, FB_ON ? 32'hFFFF_FFC0 : 32'd0);

        cmd = 32'sd0;
        run(P);
        pin("zero_start", 1'b0, 1'b0, FB_ON ? 32'hFFFF_FF80 : 32'd0);
        run(P);
        pin("zero_hold", 1'b0, 1'b0, FB_ON ? 32'hFFFF_FF80 : 32'd0);

        cmd = 32'sh8000_0000;
        run(P);
        pin("min_start", 1'b1, 1'b1, FB_ON ? 32'hFFFF_FF80 : 32'd0);
        run(P);
        pin("min_full", 1'b1, 1'b1, FB_ON ? 32'hFFFF_FE80 : 32'd0);

        reset_midpulse("rst_b");
        run(2);
        @(negedge clk);
        cmd   = 32'sd128;
        rst_n = 1'b1;
        run(P + 10);
        pin("post_rst", 1'b1, 1'b0, FB_ON ? 32'd10 : 32'd0);
        run(4);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
